mult_stim_gen: RTL

Synthesizable, parametrised stimulus generator for the signed parity-protected multiplier. It drives the multiplier's req/ack/result_rdy handshake and replaces the bench-only random/corner pattern source with an LFSR-based engine. It supports selectable operand modes, optional per-operand parity-error injection, a programmable operation count and a handshake timeout. It sits between the bench or an FPGA harness and the multiplier's input port.

---
 rtl/mult_stim_gen_pkg.sv | 27 ++
 rtl/mult_stim_gen_if.sv | 24 ++
 rtl/mult_stim_gen_lfsr32.sv | 26 ++
 rtl/mult_stim_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mult_stim_gen_pkg.sv
// Shared types and helpers for the multiplier stimulus generator:
// operand modes, FSM states, LFSR feedback mask and parity helper.
package mult_stim_pkg;

  typedef enum logic [1:0] {
    STIM_RANDOM = 2'd0,
    STIM_CORNER = 2'd1,
    STIM_MIXED  = 2'd2,
    STIM_SWEEP  = 2'd3
  } stim_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_REQ      = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_DONE     = 3'd4
  } stim_state_t;

  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  function automatic logic parity_calc(input logic [31:0] data, input logic invert);
    return (^data) ^ invert;
  endfunction

endpackage

// File: rtl/mult_stim_gen_if.sv
// Operand/handshake bundle between the stimulus generator (master)
// and the signed parity-protected multiplier (slave).
interface mult_stim_gen_if #(parameter int DATA_W = 16);

  logic signed [DATA_W-1:0] arg_a;
  logic                     arg_a_parity;
  logic signed [DATA_W-1:0] arg_b;
  logic                     arg_b_parity;
  logic                     req;
  logic                     ack;
  logic                     result_rdy;
  logic                     exp_parity_err;

  modport master (
    output arg_a, arg_a_parity, arg_b, arg_b_parity, req, exp_parity_err,
    input  ack, result_rdy
  );

  modport slave (
    input  arg_a, arg_a_parity, arg_b, arg_b_parity, req, exp_parity_err,
    output ack, result_rdy
  );

endinterface

// File: rtl/mult_stim_gen_lfsr32.sv
// 32-bit Galois LFSR with a reset seed; advances one step per enabled cycle.
module lfsr32
  import mult_stim_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [31:0] o_state
);

  logic [31:0] r_state;

  // Shift right and fold the feedback mask in when the outgoing bit is 1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEED;
    end else if (i_en) begin
      r_state <= (r_state >> 1) ^ (r_state[0] ? LFSR_POLY : 32'h0000_0000);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/mult_stim_gen.sv
// LFSR-driven operand generator for the signed parity-protected multiplier:
// drives req/ack/result_rdy, injects parity errors on request, counts ops, times out.
module mult_stim_gen
  import mult_stim_pkg::*;
#(
  parameter int          DATA_W      = 16,
  parameter int          NUM_OPS     = 1000,
  parameter int          TIMEOUT_CYC = 64,
  parameter logic [31:0] SEED_A      = 32'h0000_0001,
  parameter logic [31:0] SEED_B      = 32'h0000_ACE1
) (
  input  logic                           clk,
  input  logic                           rst,
  mult_stim_gen_if.master                bus,
  input  logic                           i_start,
  input  logic [1:0]                     i_mode,
  input  logic                           i_inj_en,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_timeout,
  output logic [$clog2(NUM_OPS+1)-1:0]   o_op_count
);

  localparam int CNT_W  = $clog2(NUM_OPS + 1);
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [DATA_W-1:0] MIN_V     = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_V     = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [CNT_W-1:0]  NUM_OPS_C = CNT_W'(NUM_OPS);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  stim_state_t       r_state, w_state_nxt;
  stim_mode_t        r_mode;
  logic              r_inj_en;
  logic [31:0]       w_lfsr_a, w_lfsr_b;
  logic [CNT_W-1:0]  r_op_count, w_count_inc;
  logic [WAIT_W-1:0] r_wait;
  logic              r_busy, r_done, r_timeout, r_req;
  logic [DATA_W-1:0] r_arg_a, r_arg_b, w_arg_a, w_arg_b;
  logic              r_par_a, r_par_b, r_exp_err;
  logic              w_fa, w_fb, w_start_ok, w_complete, w_expire, w_last_op;
  logic [1:0]        w_sweep_idx;

  lfsr32 #(.SEED(SEED_A)) u_lfsr_a (.clk(clk), .rst(rst), .i_en(1'b1), .o_state(w_lfsr_a));
  lfsr32 #(.SEED(SEED_B)) u_lfsr_b (.clk(clk), .rst(rst), .i_en(1'b1), .o_state(w_lfsr_b));

  function automatic logic [DATA_W-1:0] pick_operand(input logic [31:0] r,
                                                     input stim_mode_t m,
                                                     input logic sweep_max);
    logic [DATA_W-1:0] v;
    case (m)
      STIM_RANDOM: v = r[DATA_W-1:0];
      STIM_CORNER: v = r[29] ? MAX_V : MIN_V;
      STIM_MIXED: begin
        if (r[31:29] == 3'b000)      v = MIN_V;
        else if (r[31:29] == 3'b111) v = MAX_V;
        else                         v = r[DATA_W-1:0];
      end
      STIM_SWEEP:  v = sweep_max ? MAX_V : MIN_V;
      default:     v = r[DATA_W-1:0];
    endcase
    return v;
  endfunction

  // Operand candidates and injection flags for the LOAD cycle
  always_comb begin
    w_sweep_idx = 2'(r_op_count);
    w_fa        = r_inj_en & w_lfsr_a[28];
    w_fb        = r_inj_en & w_lfsr_b[28];
    // sweep order: (MIN,MIN) (MAX,MAX) (MIN,MAX) (MAX,MIN)
    w_arg_a     = pick_operand(w_lfsr_a, r_mode, w_sweep_idx[0]);
    w_arg_b     = pick_operand(w_lfsr_b, r_mode, w_sweep_idx[0] ^ w_sweep_idx[1]);
  end

  // Next-state logic with completion and timeout detection
  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    w_expire    = 1'b0;
    w_start_ok  = 1'b0;
    w_count_inc = (r_op_count == NUM_OPS_C) ? r_op_count : r_op_count + CNT_W'(1);
    w_last_op   = (w_count_inc == NUM_OPS_C);
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_LOAD: w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (bus.ack && bus.result_rdy) begin
          w_complete  = 1'b1;
          w_state_nxt = w_last_op ? ST_DONE : ST_LOAD;
        end else if (bus.ack) begin
          w_state_nxt = ST_WAIT_RDY;
        end else if (r_wait == WAIT_LAST) begin
          w_expire    = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_WAIT_RDY: begin
        if (bus.result_rdy) begin
          w_complete  = 1'b1;
          w_state_nxt = w_last_op ? ST_DONE : ST_LOAD;
        end else if (r_wait == WAIT_LAST) begin
          w_expire    = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_WAIT_RDY;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Run control, op/wait counters and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode     <= STIM_RANDOM;
      r_inj_en   <= 1'b0;
      r_op_count <= '0;
      r_wait     <= '0;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_req  <= (w_state_nxt == ST_REQ);
      r_busy <= (w_state_nxt inside {ST_LOAD, ST_REQ, ST_WAIT_RDY});
      if (w_start_ok) begin
        r_op_count <= '0;
        r_timeout  <= 1'b0;
        r_done     <= 1'b0;
        r_mode     <= stim_mode_t'(i_mode);
        r_inj_en   <= i_inj_en;
      end else if (w_complete) begin
        r_op_count <= w_count_inc;
        r_done     <= w_last_op;
      end else if (w_expire) begin
        r_timeout  <= 1'b1;
        r_done     <= 1'b1;
      end
      // the wait counter restarts on every state change
      if (w_state_nxt != r_state) begin
        r_wait <= '0;
      end else if (r_state == ST_REQ || r_state == ST_WAIT_RDY) begin
        r_wait <= r_wait + WAIT_W'(1);
      end
    end
  end

  // Operand and parity registers, written only in LOAD
  always_ff @(posedge clk) begin
    if (rst) begin
      r_arg_a   <= '0;
      r_arg_b   <= '0;
      r_par_a   <= 1'b0;
      r_par_b   <= 1'b0;
      r_exp_err <= 1'b0;
    end else if (r_state == ST_LOAD) begin
      r_arg_a   <= w_arg_a;
      r_arg_b   <= w_arg_b;
      r_par_a   <= parity_calc(32'(w_arg_a), w_fa);
      r_par_b   <= parity_calc(32'(w_arg_b), w_fb);
      r_exp_err <= w_fa | w_fb;
    end
  end

  assign bus.arg_a          = r_arg_a;
  assign bus.arg_a_parity   = r_par_a;
  assign bus.arg_b          = r_arg_b;
  assign bus.arg_b_parity   = r_par_b;
  assign bus.req            = r_req;
  assign bus.exp_parity_err = r_exp_err;
  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_timeout          = r_timeout;
  assign o_op_count         = r_op_count;

endmodule
